// File: rtl/node_ctrl.sv
// Per-node instruction sequencer: decodes the current instruction and drives ACC/ALU/PC/NODEIO controls.
// Optional illegal-opcode trap state enabled by defining NODE_CTRL_TRAP_EN.
module node_ctrl #(
    parameter int unsigned LAST_PC = 14
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic [3:0]  op,
    input  logic [2:0]  src,
    input  logic [2:0]  dst,
    input  logic [10:0] imm,
    input  logic [3:0]  target,
    input  logic [3:0]  pc,
    input  logic [10:0] acc_val,
    input  logic [10:0] in_data,
    input  logic        rx_complete,
    input  logic        tx_complete,
    output logic        rx,
    output logic        tx,
    output logic [1:0]  direction,
    output logic [10:0] out_data,
    output logic [1:0]  aluop,
    output logic [10:0] operand_b,
    output logic        acc_wen,
    output logic        sav,
    output logic        swp,
    output logic        jump_pc_en,
    output logic [3:0]  jump_pc,
    output logic        stall,
    output logic        trap
);

    localparam int unsigned DW = 11;
    localparam int unsigned PW = 4;
    localparam logic signed [DW:0] LAST_PC_S = (DW+1)'(LAST_PC);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_SWP = 4'd2;
    localparam logic [3:0] OP_SAV = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JEZ = 4'd8;
    localparam logic [3:0] OP_JNZ = 4'd9;
    localparam logic [3:0] OP_JGZ = 4'd10;
    localparam logic [3:0] OP_JLZ = 4'd11;
    localparam logic [3:0] OP_JRO = 4'd12;

    localparam logic [2:0] LOC_IMM = 3'd0;
    localparam logic [2:0] LOC_ACC = 3'd1;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;
    localparam logic [1:0] ALU_NEG  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_RX_WAIT,
        S_TX_WAIT
`ifdef NODE_CTRL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  hold_q, hold_d;

    logic           uses_src;
    logic           src_port;
    logic           dst_port;
    logic           illegal;
    logic [DW-1:0]  src_val;
    logic [1:0]     src_dir;
    logic [1:0]     dst_dir;
    logic signed [DW:0] jro_sum;
    logic [PW-1:0]  jro_pc;
    logic           acc_zero;
    logic           acc_neg;
    logic           fin;

    function automatic logic is_port(input logic [2:0] loc);
        return (loc >= 3'd3) && (loc <= 3'd6);
    endfunction

    // Ports are encoded 3..6; direction is the offset from UP.
    function automatic logic [1:0] port_dir(input logic [2:0] loc);
        return 2'(loc - 3'd3);
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Instruction field decode shared by all states.
    always_comb begin
        uses_src = (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_JRO);
        src_port = uses_src && is_port(src);
        dst_port = (op == OP_MOV) && is_port(dst);
        illegal  = (op > OP_JRO);
        src_dir  = port_dir(src);
        dst_dir  = port_dir(dst);
        acc_zero = (acc_val == '0);
        acc_neg  = acc_val[DW-1];
        case (src)
            LOC_IMM:                    src_val = imm;
            LOC_ACC:                    src_val = acc_val;
            3'd3, 3'd4, 3'd5, 3'd6:     src_val = in_data;
            default:                    src_val = '0;
        endcase
        jro_sum = $signed({{(DW+1-PW){1'b0}}, pc}) + $signed({src_val[DW-1], src_val});
        if (jro_sum < 0) begin
            jro_pc = '0;
        end else if (jro_sum > LAST_PC_S) begin
            jro_pc = LAST_PC_S[PW-1:0];
        end else begin
            jro_pc = jro_sum[PW-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        rx         = 1'b0;
        tx         = 1'b0;
        direction  = 2'd0;
        out_data   = '0;
        aluop      = ALU_PASS;
        operand_b  = '0;
        acc_wen    = 1'b0;
        sav        = 1'b0;
        swp        = 1'b0;
        jump_pc_en = 1'b0;
        jump_pc    = '0;
        stall      = 1'b1;
        trap       = 1'b0;
        fin        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!halt) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!halt) begin
                    if (illegal) begin
`ifdef NODE_CTRL_TRAP_EN
                        state_d = S_TRAP;
`else
                        fin = 1'b1;
`endif
                    end else if (src_port) begin
                        rx        = 1'b1;
                        direction = src_dir;
                        if (rx_complete) begin
                            if (dst_port) begin
                                hold_d  = in_data;
                                state_d = S_TX_WAIT;
                            end else begin
                                fin = 1'b1;
                            end
                        end else begin
                            state_d = S_RX_WAIT;
                        end
                    end else if (dst_port) begin
                        tx        = 1'b1;
                        direction = dst_dir;
                        out_data  = src_val;
                        if (tx_complete) begin
                            fin = 1'b1;
                        end else begin
                            hold_d  = src_val;
                            state_d = S_TX_WAIT;
                        end
                    end else begin
                        fin = 1'b1;
                    end
                end
            end
            S_RX_WAIT: begin
                if (!halt) begin
                    rx        = 1'b1;
                    direction = src_dir;
                    if (rx_complete) begin
                        if (dst_port) begin
                            hold_d  = in_data;
                            state_d = S_TX_WAIT;
                        end else begin
                            fin     = 1'b1;
                            state_d = S_EXEC;
                        end
                    end
                end
            end
            S_TX_WAIT: begin
                if (!halt) begin
                    tx        = 1'b1;
                    direction = dst_dir;
                    out_data  = hold_q;
                    if (tx_complete) begin
                        fin     = 1'b1;
                        state_d = S_EXEC;
                    end
                end
            end
`ifdef NODE_CTRL_TRAP_EN
            S_TRAP: begin
                trap = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes and PC redirect fire only in the completing cycle.
        if (fin) begin
            stall = 1'b0;
            case (op)
                OP_MOV: begin
                    if (dst == LOC_ACC) begin
                        aluop     = ALU_PASS;
                        operand_b = src_val;
                        acc_wen   = 1'b1;
                    end
                end
                OP_ADD: begin
                    aluop     = ALU_ADD;
                    operand_b = src_val;
                    acc_wen   = 1'b1;
                end
                OP_SUB: begin
                    aluop     = ALU_SUB;
                    operand_b = src_val;
                    acc_wen   = 1'b1;
                end
                OP_NEG: begin
                    aluop   = ALU_NEG;
                    acc_wen = 1'b1;
                end
                OP_SWP: swp = 1'b1;
                OP_SAV: sav = 1'b1;
                OP_JMP: begin
                    jump_pc_en = 1'b1;
                    jump_pc    = target;
                end
                OP_JEZ: begin
                    jump_pc_en = acc_zero;
                    jump_pc    = acc_zero ? target : '0;
                end
                OP_JNZ: begin
                    jump_pc_en = !acc_zero;
                    jump_pc    = !acc_zero ? target : '0;
                end
                OP_JGZ: begin
                    jump_pc_en = !acc_zero && !acc_neg;
                    jump_pc    = (!acc_zero && !acc_neg) ? target : '0;
                end
                OP_JLZ: begin
                    jump_pc_en = acc_neg;
                    jump_pc    = acc_neg ? target : '0;
                end
                OP_JRO: begin
                    jump_pc_en = 1'b1;
                    jump_pc    = jro_pc;
                end
                OP_NOP: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_node_ctrl.sv
// Scoreboard bench for node_ctrl: the driver queues hand-computed per-cycle outputs, a monitor compares them.
module tb_node_ctrl;

    typedef struct packed {
        logic        rx;
        logic        tx;
        logic [1:0]  dir;
        logic [10:0] od;
        logic [1:0]  alu;
        logic [10:0] opb;
        logic        wen;
        logic        sav;
        logic        swp;
        logic        jen;
        logic [3:0]  jpc;
        logic        stall;
        logic        trap;
    } out_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        halt;
    logic [3:0]  op;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [10:0] imm;
    logic [3:0]  target;
    logic [3:0]  pc;
    logic [10:0] acc_val;
    logic [10:0] in_data;
    logic        rx_complete;
    logic        tx_complete;
    logic        rx;
    logic        tx;
    logic [1:0]  direction;
    logic [10:0] out_data;
    logic [1:0]  aluop;
    logic [10:0] operand_b;
    logic        acc_wen;
    logic        sav;
    logic        swp;
    logic        jump_pc_en;
    logic [3:0]  jump_pc;
    logic        stall;
    logic        trap;

    out_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    node_ctrl #(.LAST_PC(14)) dut (
        .CLK(CLK), .RST(RST), .halt(halt), .op(op), .src(src), .dst(dst),
        .imm(imm), .target(target), .pc(pc), .acc_val(acc_val), .in_data(in_data),
        .rx_complete(rx_complete), .tx_complete(tx_complete),
        .rx(rx), .tx(tx), .direction(direction), .out_data(out_data),
        .aluop(aluop), .operand_b(operand_b), .acc_wen(acc_wen), .sav(sav), .swp(swp),
        .jump_pc_en(jump_pc_en), .jump_pc(jump_pc), .stall(stall), .trap(trap)
    );

    always #5 CLK = ~CLK;

    // Monitor: one expected output vector per cycle, sampled mid-cycle.
    always @(negedge CLK) begin
        out_t  got;
        out_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            got = {rx, tx, direction, out_data, aluop, operand_b, acc_wen, sav, swp,
                   jump_pc_en, jump_pc, stall, trap};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h (rx tx dir od alu opb wen sav swp jen jpc stall trap)",
                         n, got, e);
            end
        end
    end

    task automatic cyc(input string n, input out_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        halt = 0; op = 4'd0; src = 3'd2; dst = 3'd2; imm = '0; target = '0;
        pc = '0; acc_val = '0; in_data = '0; rx_complete = 0; tx_complete = 0;
    endtask

    function automatic out_t busy();
        out_t e;
        e = '0;
        e.stall = 1'b1;
        return e;
    endfunction

    initial begin
        out_t e;
        RST = 1'b1;
        quiet();
        @(posedge CLK);
        #1;
        cyc("reset", busy());

        RST = 1'b0; op = 4'd4; src = 3'd0; imm = 11'd5;
        cyc("idle_after_reset", busy());
        e = '0; e.alu = 2'd1; e.opb = 11'd5; e.wen = 1;
        cyc("add_imm", e);

        op = 4'd5; src = 3'd1; acc_val = 11'd100;
        e = '0; e.alu = 2'd2; e.opb = 11'd100; e.wen = 1;
        cyc("sub_acc", e);
        quiet(); op = 4'd6;
        e = '0; e.alu = 2'd3; e.wen = 1;
        cyc("neg", e);
        op = 4'd2; e = '0; e.swp = 1; cyc("swp", e);
        op = 4'd3; e = '0; e.sav = 1; cyc("sav", e);
        op = 4'd1; src = 3'd0; dst = 3'd2; imm = 11'd9;
        cyc("mov_imm_nil", '0);

        quiet(); op = 4'd1; src = 3'd3; dst = 3'd1; in_data = 11'h7F9;
        e = busy(); e.rx = 1; e.dir = 2'd0;
        cyc("mov_up_wait1", e);
        cyc("mov_up_wait2", e);
        rx_complete = 1;
        e = '0; e.rx = 1; e.dir = 2'd0; e.opb = 11'h7F9; e.wen = 1;
        cyc("mov_up_done", e);

        quiet(); op = 4'd1; src = 3'd5; dst = 3'd6; in_data = 11'd42; rx_complete = 1;
        e = busy(); e.rx = 1; e.dir = 2'd2;
        cyc("p2p_rx", e);
        rx_complete = 0; in_data = '0;
        e = busy(); e.tx = 1; e.dir = 2'd3; e.od = 11'd42;
        cyc("p2p_tx_wait", e);
        tx_complete = 1;
        e.stall = 0;
        cyc("p2p_done", e);

        quiet(); op = 4'd12; src = 3'd0; pc = 4'd3; imm = 11'h7F7;
        e = '0; e.jen = 1; e.jpc = 4'd0;
        cyc("jro_clamp_low", e);
        imm = 11'd50; e.jpc = 4'd14;
        cyc("jro_clamp_high", e);
        imm = 11'd4; e.jpc = 4'd7;
        cyc("jro_mid", e);

        quiet(); op = 4'd10; target = 4'd9; acc_val = 11'd0;
        cyc("jgz_zero", '0);
        acc_val = 11'd1;
        e = '0; e.jen = 1; e.jpc = 4'd9;
        cyc("jgz_pos", e);
        op = 4'd11; acc_val = 11'h7FF;
        cyc("jlz_neg", e);
        op = 4'd8; acc_val = 11'd0;
        cyc("jez_zero", e);
        op = 4'd9;
        cyc("jnz_zero", '0);
        op = 4'd7; target = 4'd5; e.jpc = 4'd5;
        cyc("jmp", e);

        quiet(); op = 4'd1; src = 3'd0; dst = 3'd4; imm = 11'd123;
        e = busy(); e.tx = 1; e.dir = 2'd1; e.od = 11'd123;
        cyc("tx_wait", e);
        imm = '0; halt = 1; tx_complete = 1;
        cyc("halt_in_tx", busy());
        halt = 0;
        e.stall = 0;
        cyc("tx_done_hold", e);
        tx_complete = 1; dst = 3'd3; imm = 11'd77;
        e = '0; e.tx = 1; e.dir = 2'd0; e.od = 11'd77;
        cyc("tx_same_cycle", e);

        quiet(); op = 4'd1; src = 3'd3; dst = 3'd1; halt = 1; rx_complete = 1;
        cyc("halt_ignores_rx", busy());
        halt = 0; rx_complete = 0;
        e = busy(); e.rx = 1;
        cyc("rx_after_halt", e);
        RST = 1;
        cyc("reset_mid_rx", busy());
        RST = 0; quiet();
        cyc("idle_again", busy());
        cyc("nop", '0);

        op = 4'd14;
`ifdef NODE_CTRL_TRAP_EN
        cyc("illegal_enter", busy());
        op = 4'd0;
        e = busy(); e.trap = 1;
        cyc("trap_hold1", e);
        cyc("trap_hold2", e);
`else
        cyc("illegal_nop", '0);
        op = 4'd0;
        cyc("after_illegal", '0);
`endif
        RST = 1;
        cyc("final_reset", busy());

        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
